// File: rtl/clock_divider_pkg.sv
// Shared constants and parameter helpers for the multi-channel clock divider.
package clock_divider_pkg;

    localparam int unsigned DEF_HALF_20HZ = 1250000;
    localparam int unsigned DEF_HALF_1HZ  = 25000000;

    // Channel-select width; never narrower than one bit so a single channel still has a select.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// Control and output bundle of the multi-channel clock divider.
interface clock_divider_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24
);
    import clock_divider_pkg::*;

    localparam int CH_W = ch_width(NUM_CH);

    logic              en;
    logic              sync;
    logic              load;
    logic [CH_W-1:0]   load_ch;
    logic [CNT_W-1:0]  load_half;
    logic [NUM_CH-1:0] div_out;
    logic [NUM_CH-1:0] tick;
    logic              ack;

    modport master (
        output en, sync, load, load_ch, load_half,
        input  div_out, tick, ack
    );

    modport slave (
        input  en, sync, load, load_ch, load_half,
        output div_out, tick, ack
    );

endinterface

// File: rtl/clock_divider_channel.sv
// One divider channel: half-period counter, active/shadow half-period and registered outputs.
module clock_divider_channel #(
    parameter int          CNT_W    = 24,
    parameter int unsigned DEF_HALF = 1250000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_half_i,
    output logic             div_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] DEF_L = CNT_W'(DEF_HALF);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             stopped;
    logic             terminal;

    always_comb begin
        cnt_d    = cnt_q;
        act_d    = act_q;
        shd_d    = shd_q;
        pend_d   = pend_q;
        div_d    = div_q;
        tick_d   = 1'b0;
        stopped  = (act_q == '0);
        terminal = (cnt_q >= act_q - CNT_W'(1));

        if (sync_i) begin
            cnt_d = '0;
            div_d = 1'b0;
            if (pend_q) begin
                act_d  = shd_q;
                pend_d = 1'b0;
            end
            if (wr_i) begin
                shd_d  = wr_half_i;
                pend_d = 1'b1;
            end
        end else if (!en_i) begin
            if (wr_i) begin
                shd_d  = wr_half_i;
                pend_d = 1'b1;
            end
        end else if (stopped) begin
            // A stopped channel has no terminal count to wait for, so it adopts a new value at once.
            cnt_d = '0;
            div_d = 1'b0;
            if (wr_i) begin
                act_d  = wr_half_i;
                shd_d  = wr_half_i;
                pend_d = 1'b0;
            end else if (pend_q) begin
                act_d  = shd_q;
                pend_d = 1'b0;
            end
        end else begin
            if (terminal) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (pend_q) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                end
                div_d = (pend_q && shd_q == '0) ? 1'b0 : ~div_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (wr_i) begin
                shd_d  = wr_half_i;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            act_q  <= DEF_L;
            shd_q  <= DEF_L;
            pend_q <= 1'b0;
            div_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign div_o  = div_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel clock divider: load decode, load acknowledge and fan-out to the channels.
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int          NUM_CH   = 4,
    parameter int          CNT_W    = 24,
    parameter int unsigned DEF_HALF = DEF_HALF_20HZ
) (
    input  logic                  clk,
    input  logic                  rst,
    clock_divider_multi_if.slave  bus
);

    localparam int              CH_W     = ch_width(NUM_CH);
    localparam logic [CH_W:0]   NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic              load_ok;
    logic              ack_q, ack_d;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] div_w;
    logic [NUM_CH-1:0] tick_w;

    // Out-of-range channel indices are dropped here and never acknowledged.
    always_comb begin
        load_ok = bus.load && ({1'b0, bus.load_ch} < NUM_CH_L);
        ack_d   = load_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = load_ok && (bus.load_ch == CH_W'(i));

        clock_divider_channel #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (rst),
            .en_i      (bus.en),
            .sync_i    (bus.sync),
            .wr_i      (wr[i]),
            .wr_half_i (bus.load_half),
            .div_o     (div_w[i]),
            .tick_o    (tick_w[i])
        );
    end

    assign bus.div_out = div_w;
    assign bus.tick    = tick_w;
    assign bus.ack     = ack_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi with a per-cycle behavioural model and literal anchors.
module tb_clock_divider_multi;

    typedef struct {
        int rem;
        int act;
        int shd;
        bit pend;
        bit div;
        bit tick;
    } ch_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   m_live = 1'b0;
    bit   m_ack  = 1'b0;
    ch_t  m [2];

    always #5 clk = ~clk;

    clock_divider_multi_if #(.NUM_CH(2), .CNT_W(8)) bus ();
    clock_divider_multi_if #(.NUM_CH(3), .CNT_W(8)) bus3 ();

    clock_divider_multi #(.NUM_CH(2), .CNT_W(8), .DEF_HALF(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    clock_divider_multi #(.NUM_CH(3), .CNT_W(8), .DEF_HALF(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // rem = clk cycles left in the current half-period, including the terminal one.
    function automatic ch_t step_ch(ch_t s, bit en, bit sy, bit wr, int h);
        ch_t n = s;
        n.tick = 1'b0;
        if (sy) begin
            if (s.pend) begin
                n.act  = s.shd;
                n.pend = 1'b0;
            end
            n.rem = n.act;
            n.div = 1'b0;
            if (wr) begin
                n.shd  = h;
                n.pend = 1'b1;
            end
        end else if (!en) begin
            if (wr) begin
                n.shd  = h;
                n.pend = 1'b1;
            end
        end else if (s.act == 0) begin
            n.div = 1'b0;
            if (wr) begin
                n.act  = h;
                n.shd  = h;
                n.pend = 1'b0;
                n.rem  = h;
            end else if (s.pend) begin
                n.act  = s.shd;
                n.pend = 1'b0;
                n.rem  = n.act;
            end
        end else begin
            if (s.rem <= 1) begin
                n.tick = 1'b1;
                if (s.pend) begin
                    n.act  = s.shd;
                    n.pend = 1'b0;
                end
                n.div = (n.act == 0) ? 1'b0 : !s.div;
                n.rem = n.act;
            end else begin
                n.rem = s.rem - 1;
            end
            if (wr) begin
                n.shd  = h;
                n.pend = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_live <= 1'b1;
            cyc    <= 0;
            m_ack  <= 1'b0;
            for (int c = 0; c < 2; c++)
                m[c] <= '{rem: 3, act: 3, shd: 3, pend: 1'b0, div: 1'b0, tick: 1'b0};
        end else begin
            cyc   <= cyc + 1;
            m_ack <= bus.load;
            for (int c = 0; c < 2; c++)
                m[c] <= step_ch(m[c], bus.en, bus.sync,
                                bus.load && (int'(bus.load_ch) == c), int'(bus.load_half));
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_div_out", 32'(bus.div_out), 32'({m[1].div, m[0].div}));
            check("model_tick", 32'(bus.tick), 32'({m[1].tick, m[0].tick}));
            check("model_ack", 32'(bus.ack), 32'(m_ack));
        end
    end

    task automatic until_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic do_load(input int ch, input int h);
        bus.load      = 1'b1;
        bus.load_ch   = 1'(ch);
        bus.load_half = 8'(h);
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.en         = 1'b1;
        bus.sync       = 1'b0;
        bus.load       = 1'b0;
        bus.load_ch    = '0;
        bus.load_half  = '0;
        bus3.en        = 1'b0;
        bus3.sync      = 1'b0;
        bus3.load      = 1'b0;
        bus3.load_ch   = '0;
        bus3.load_half = '0;

        repeat (2) @(negedge clk);
        check("rst_div", 32'(bus.div_out), 32'h0);
        check("rst_tick", 32'(bus.tick), 32'h0);
        check("rst_ack", 32'(bus.ack), 32'h0);
        rst = 1'b0;

        // default half-period 3: toggles at cycles 3, 6, 9 ...
        until_cyc(2);
        check("first_before", 32'(bus.div_out), 32'h0);
        until_cyc(3);
        check("first_rise", 32'(bus.div_out), 32'h3);
        check("first_tick", 32'(bus.tick), 32'h3);
        until_cyc(6);
        check("first_fall", 32'(bus.div_out), 32'h0);
        check("first_fall_tick", 32'(bus.tick), 32'h3);

        // mid-period reload ch0 -> 5 takes effect at the toggle on cycle 9
        do_load(0, 5);
        check("reload_ack", 32'(bus.ack), 32'h1);
        until_cyc(9);
        check("reload_toggle9", 32'(bus.div_out), 32'h3);
        until_cyc(13);
        check("reload_c13", 32'(bus.div_out), 32'h1);
        until_cyc(14);
        check("reload_c14_div", 32'(bus.div_out), 32'h0);
        check("reload_c14_tick", 32'(bus.tick), 32'h1);

        // stop ch1 (load lands on its own terminal count), then restart with half 2
        do_load(1, 0);
        until_cyc(30);
        check("stop_div1", 32'(bus.div_out[1]), 32'h0);
        check("stop_tick1", 32'(bus.tick[1]), 32'h0);
        do_load(1, 2);
        check("restart_c31", 32'(bus.div_out[1]), 32'h0);
        until_cyc(32);
        check("restart_c32", 32'(bus.div_out[1]), 32'h0);
        until_cyc(33);
        check("restart_c33_div", 32'(bus.div_out[1]), 32'h1);
        check("restart_c33_tick", 32'(bus.tick[1]), 32'h1);

        // four frozen cycles stretch ch1's half-period from 2 to 6
        bus.en = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("freeze_tick", 32'(bus.tick), 32'h0);
        end
        bus.en = 1'b1;
        until_cyc(38);
        check("freeze_c38", 32'(bus.div_out[1]), 32'h1);
        until_cyc(39);
        check("freeze_c39_div", 32'(bus.div_out[1]), 32'h0);
        check("freeze_c39_tick", 32'(bus.tick[1]), 32'h1);

        // sync plus load: ch0 keeps half 5 for one half-period, then 4
        until_cyc(40);
        bus.sync = 1'b1;
        do_load(0, 4);
        bus.sync = 1'b0;
        check("sync_div", 32'(bus.div_out), 32'h0);
        check("sync_tick", 32'(bus.tick), 32'h0);
        until_cyc(45);
        check("sync_c45", 32'(bus.div_out[0]), 32'h0);
        until_cyc(46);
        check("sync_c46_div", 32'(bus.div_out[0]), 32'h1);
        check("sync_c46_tick", 32'(bus.tick[0]), 32'h1);
        until_cyc(50);
        check("sync_c50_div", 32'(bus.div_out[0]), 32'h0);
        check("sync_c50_tick", 32'(bus.tick[0]), 32'h1);

        // reset while ch1 is high and ch0 has a pending shadow
        do_load(0, 6);
        check("prerst_div1", 32'(bus.div_out[1]), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_div", 32'(bus.div_out), 32'h0);
        check("midrst_tick", 32'(bus.tick), 32'h0);
        check("midrst_ack", 32'(bus.ack), 32'h0);
        rst = 1'b0;
        until_cyc(2);
        check("postrst_c2", 32'(bus.div_out), 32'h0);
        until_cyc(3);
        check("postrst_c3", 32'(bus.div_out), 32'h3);

        // three-channel build: index 3 is out of range
        bus3.load      = 1'b1;
        bus3.load_ch   = 2'd3;
        bus3.load_half = 8'd7;
        @(negedge clk);
        bus3.load = 1'b0;
        check("inv_ch_ack", 32'(bus3.ack), 32'h0);
        bus3.load    = 1'b1;
        bus3.load_ch = 2'd2;
        @(negedge clk);
        bus3.load = 1'b0;
        check("valid_ch2_ack", 32'(bus3.ack), 32'h1);
        @(negedge clk);
        check("ack_one_cycle", 32'(bus3.ack), 32'h0);
        check("dut3_frozen_div", 32'(bus3.div_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
